mem_bus_arbiter: RTL

Sits directly downstream of the pipelined CPU's instruction-fetch and data-memory ports. It merges the two ports onto one single-port memory bus with a variable-latency req/ack handshake. It also drives a stall back to the CPU until every access requested in the current CPU cycle has completed. Read data is returned to the CPU through registered holding latches, valid during the single non-stalled completion cycle.

---
 rtl/mem_bus_arbiter_if.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// CPU-side and memory-bus-side signal bundle for mem_bus_arbiter.
// The arbiter uses the slave view; the CPU/memory environment uses the master view.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // CPU instruction-fetch port
  logic              rom_ce;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] inst_to_cpu;
  // CPU data-memory port
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_byte_slct;
  logic [DATA_W-1:0] data_to_write_mem;
  logic [DATA_W-1:0] data_from_mem;
  logic              cpu_stall;
  // Single-port memory bus
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_ack;
  logic              bus_timeout;

  modport slave (
    input  rom_ce, rom_addr, mem_re, mem_we, mem_addr, mem_byte_slct,
           data_to_write_mem, bus_rdata, bus_ack,
    output inst_to_cpu, data_from_mem, cpu_stall, bus_req, bus_we,
           bus_addr, bus_be, bus_wdata, bus_timeout
  );

  modport master (
    output rom_ce, rom_addr, mem_re, mem_we, mem_addr, mem_byte_slct,
           data_to_write_mem, bus_rdata, bus_ack,
    input  inst_to_cpu, data_from_mem, cpu_stall, bus_req, bus_we,
           bus_addr, bus_be, bus_wdata, bus_timeout
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Merges the CPU fetch and data ports onto one req/ack memory bus.
// Data access goes first, then the fetch from the same CPU cycle; the CPU is
// stalled until both have retired. Each wait is bounded by a timeout counter.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  mem_bus_arbiter_if.slave    arb
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_D_WAIT = 2'd1;
  localparam logic [1:0] S_I_WAIT = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // Last wait cycle index; reaching it without an ack aborts the transaction.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic              pend_i_q, pend_i_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        cnt_q, cnt_d;

  logic              wait_st;
  logic              expired;
  logic              xfer_done;
  logic [DATA_W-1:0] rdata;

  // The bus is word addressed; byte offset is carried by bus_be.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~(ADDR_W'(3));
  endfunction

  // Completion detection: a real ack wins over a simultaneous timeout.
  always_comb begin
    wait_st   = (state_q == S_D_WAIT) || (state_q == S_I_WAIT);
    expired   = wait_st && !arb.bus_ack && (cnt_q == TO_LAST);
    xfer_done = wait_st && (arb.bus_ack || expired);
    rdata     = arb.bus_ack ? arb.bus_rdata : '0;
  end

  // Next-state logic for the sequencer and the registered bus fields.
  always_comb begin
    // NOTE: every _d starts from its _q so no path through the case leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pend_i_d    = pend_i_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    inst_d      = inst_q;
    data_d      = data_q;
    timeout_d   = timeout_q | expired;
    cnt_d       = (wait_st && !xfer_done) ? cnt_q + 8'd1 : cnt_q;

    case (state_q)
      S_IDLE: begin
        pend_i_d = arb.rom_ce;
        if (arb.mem_re || arb.mem_we) begin
          bus_req_d   = 1'b1;
          bus_we_d    = arb.mem_we;
          bus_addr_d  = word_addr(arb.mem_addr);
          bus_be_d    = arb.mem_we ? arb.mem_byte_slct : 4'b1111;
          bus_wdata_d = arb.data_to_write_mem;
          cnt_d       = '0;
          state_d     = S_D_WAIT;
        end else if (arb.rom_ce) begin
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = word_addr(arb.rom_addr);
          bus_be_d    = 4'b1111;
          cnt_d       = '0;
          state_d     = S_I_WAIT;
        end
      end
      S_D_WAIT: begin
        if (xfer_done) begin
          if (!bus_we_q) data_d = rdata;
          if (pend_i_q) begin
            // Chain straight into the fetch; bus_req stays high.
            bus_we_d   = 1'b0;
            bus_addr_d = word_addr(arb.rom_addr);
            bus_be_d   = 4'b1111;
            cnt_d      = '0;
            state_d    = S_I_WAIT;
          end else begin
            bus_req_d = 1'b0;
            state_d   = S_DONE;
          end
        end
      end
      S_I_WAIT: begin
        if (xfer_done) begin
          inst_d    = rdata;
          bus_req_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset aborts any in-flight request immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pend_i_q    <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
      inst_q      <= '0;
      data_q      <= '0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q     <= state_d;
      pend_i_q    <= pend_i_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
      inst_q      <= inst_d;
      data_q      <= data_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  // Stall only while a request is outstanding; DONE releases the CPU for one cycle.
  assign arb.cpu_stall = rst && (state_q != S_DONE) &&
                         (arb.rom_ce || arb.mem_re || arb.mem_we);

  assign arb.bus_req       = bus_req_q;
  assign arb.bus_we        = bus_we_q;
  assign arb.bus_addr      = bus_addr_q;
  assign arb.bus_be        = bus_be_q;
  assign arb.bus_wdata     = bus_wdata_q;
  assign arb.bus_timeout   = timeout_q;
  assign arb.inst_to_cpu   = inst_q;
  assign arb.data_from_mem = data_q;

endmodule
